// File: rtl/neuron_mac.sv
// neuron_mac: one neuron's multiply-accumulate engine.
// Streams numInputs signed fixed-point activations, multiplies each by a stored
// weight, accumulates at full 2*dataWidth precision with saturation, adds the
// Q-aligned bias and emits one saturated sum per vector as a one-cycle pulse.
module neuron_mac #(
  parameter int dataWidth = 16,
  parameter int intPart   = 4,
  parameter int numInputs = 784,
  parameter int addrWidth = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wt_wr_en,
  input  logic [addrWidth-1:0]      wt_wr_addr,
  input  logic [dataWidth-1:0]      wt_wr_data,
  input  logic                      bias_wr_en,
  input  logic [dataWidth-1:0]      bias_wr_data,
  input  logic                      in_valid,
  input  logic [dataWidth-1:0]      in_data,
  output logic                      busy,
  output logic                      out_valid,
  output logic [2*dataWidth-1:0]    out_sum
);

  localparam int fracBits = dataWidth - intPart;
  localparam int accWidth = 2 * dataWidth;
  localparam logic [addrWidth-1:0] lastIdx = addrWidth'(numInputs - 1);
  localparam logic [addrWidth:0]   memDepth = (addrWidth + 1)'(numInputs);
  localparam logic signed [accWidth-1:0] satMax = {1'b0, {(accWidth-1){1'b1}}};
  localparam logic signed [accWidth-1:0] satMin = {1'b1, {(accWidth-1){1'b0}}};

  // Weight storage; intentionally not cleared by reset.
  logic signed [dataWidth-1:0] wt_mem_q [numInputs];

  logic [addrWidth-1:0]        in_cnt_q, in_cnt_d;
  logic                        in_last;
  logic                        s1_valid_q, s1_last_q;
  logic signed [dataWidth-1:0] s1_data_q, s1_wt_q;
  logic                        s2_valid_q, s2_last_q;
  logic signed [accWidth-1:0]  s2_prod_q;
  logic signed [accWidth-1:0]  prod;
  logic signed [accWidth-1:0]  acc_q, acc_d;
  logic signed [accWidth-1:0]  acc_plus;
  logic signed [accWidth-1:0]  bias_al;
  logic signed [dataWidth-1:0] bias_q;
  logic                        out_valid_q, out_valid_d;
  logic signed [accWidth-1:0]  out_sum_q, out_sum_d;
  logic                        wr_allowed, wt_wr_ok, bias_wr_ok;

  // Signed add that clamps to the most positive / most negative value on overflow.
  function automatic logic signed [accWidth-1:0] satAdd(
    input logic signed [accWidth-1:0] a,
    input logic signed [accWidth-1:0] b
  );
    logic [accWidth:0] wide;
    wide = {a[accWidth-1], a} + {b[accWidth-1], b};
    if (wide[accWidth] != wide[accWidth-1]) begin
      return wide[accWidth] ? satMin : satMax;
    end
    return wide[accWidth-1:0];
  endfunction

  assign busy       = (in_cnt_q != '0) | s1_valid_q | s2_valid_q;
  assign wr_allowed = ~busy & ~in_valid;
  assign wt_wr_ok   = wt_wr_en & wr_allowed & ({1'b0, wt_wr_addr} < memDepth);
  assign bias_wr_ok = bias_wr_en & wr_allowed;

  assign prod     = accWidth'(s1_data_q) * accWidth'(s1_wt_q);
  assign bias_al  = {{intPart{bias_q[dataWidth-1]}}, bias_q, {fracBits{1'b0}}};
  assign acc_plus = satAdd(acc_q, s2_prod_q);

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  // Input counter: selects the weight for each sample and tags the last one of a vector.
  always_comb begin
    in_cnt_d = in_cnt_q;
    in_last  = in_valid && (in_cnt_q == lastIdx);
    if (in_valid) begin
      in_cnt_d = in_last ? '0 : in_cnt_q + 1'b1;
    end
  end

  // Accumulate stage: fold each product in, and on the last one add bias and publish.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    if (s2_valid_q) begin
      if (s2_last_q) begin
        out_sum_d   = satAdd(acc_plus, bias_al);
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_plus;
      end
    end
  end

  // Weight RAM: gated writes plus a synchronous read of the weight for the incoming sample.
  always_ff @(posedge clk) begin
    if (wt_wr_ok) begin
      wt_mem_q[wt_wr_addr] <= wt_wr_data;
    end
    if (in_valid) begin
      s1_wt_q <= wt_mem_q[in_cnt_q];
    end
  end

  // Pipeline, accumulator, bias and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      in_cnt_q   <= in_cnt_d;
      s1_valid_q <= in_valid;
      s1_last_q  <= in_last;
      if (in_valid) begin
        s1_data_q <= in_data;
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod;
      end
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      if (bias_wr_ok) begin
        bias_q <= bias_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac with a 4-input neuron.
module tb_neuron_mac;

  logic        clk;
  logic        rst_n;
  logic        wt_wr_en;
  logic [1:0]  wt_wr_addr;
  logic [15:0] wt_wr_data;
  logic        bias_wr_en;
  logic [15:0] bias_wr_data;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_sum;

  neuron_mac #(
    .dataWidth(16),
    .intPart(4),
    .numInputs(4),
    .addrWidth(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wt_wr_en(wt_wr_en),
    .wt_wr_addr(wt_wr_addr),
    .wt_wr_data(wt_wr_data),
    .bias_wr_en(bias_wr_en),
    .bias_wr_data(bias_wr_data),
    .in_valid(in_valid),
    .in_data(in_data),
    .busy(busy),
    .out_valid(out_valid),
    .out_sum(out_sum)
  );

  int compared = 0;
  int mismatched = 0;
  int edgeCount = 0;
  int lastFeedEdge = -100;
  int tbCnt = 0;

  logic signed [15:0] modelWt [4];
  logic signed [15:0] modelBias;
  logic signed [15:0] curVec [4];
  logic signed [15:0] stimVec [4];
  logic [31:0] expQ [$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so the model knows when the pipeline has drained.
  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic longint clampSum(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Reference: running dot product clamped after every addition, then bias in Q24.
  function automatic logic [31:0] refSum();
    longint acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc = clampSum(acc + longint'(curVec[k]) * longint'(modelWt[k]));
    end
    acc = clampSum(acc + longint'(modelBias) * 64'sd4096);
    return acc[31:0];
  endfunction

  // Writes are accepted only with no vector in flight and the pipeline drained.
  function automatic bit modelIdle();
    return (tbCnt == 0) && (edgeCount + 1 >= lastFeedEdge + 3);
  endfunction

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    repeat (4) idleCycle();
  endtask

  task automatic feedOne(input logic [15:0] data);
    in_valid = 1'b1;
    in_data = data;
    curVec[tbCnt] = data;
    lastFeedEdge = edgeCount + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    if (tbCnt == 3) begin
      expQ.push_back(refSum());
      tbCnt = 0;
    end else begin
      tbCnt++;
    end
  endtask

  task automatic writeWeight(input logic [1:0] addr, input logic [15:0] data);
    wt_wr_en = 1'b1;
    wt_wr_addr = addr;
    wt_wr_data = data;
    if (modelIdle()) modelWt[addr] = data;
    @(posedge clk);
    #1;
    wt_wr_en = 1'b0;
  endtask

  task automatic writeBias(input logic [15:0] data);
    bias_wr_en = 1'b1;
    bias_wr_data = data;
    if (modelIdle()) modelBias = data;
    @(posedge clk);
    #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic setWeights(input logic [15:0] data);
    for (int a = 0; a < 4; a++) writeWeight(2'(a), data);
  endtask

  task automatic setStim(input logic [15:0] data);
    for (int k = 0; k < 4; k++) stimVec[k] = data;
  endtask

  // gapMode: 0 = back-to-back, 1 = one idle cycle between samples, 2 = random gaps.
  task automatic applyStimulus(input int gapMode);
    for (int k = 0; k < 4; k++) begin
      if (k > 0 && (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1))) idleCycle();
      feedOne(stimVec[k]);
    end
  endtask

  task automatic waitPulse(input string name, input logic [31:0] expected);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      checkOutput(name, out_sum, expected);
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no out_valid within 10 cycles, expected sum 0x%08h", name, expected);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expected sum.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedPulse: got 0x%08h with no sum pending", out_sum);
      end else begin
        checkOutput("scoreboard", out_sum, expQ.pop_front());
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    rst_n = 1'b0;
    wt_wr_en = 1'b0;
    wt_wr_addr = '0;
    wt_wr_data = '0;
    bias_wr_en = 1'b0;
    bias_wr_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    modelBias = '0;
    for (int a = 0; a < 4; a++) modelWt[a] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutSum", out_sum, 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycle();

    // Basic vector with exact latency check.
    setWeights(16'h1000);
    writeBias(16'h0800);
    setStim(16'h1000);
    applyStimulus(0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("latencyEarly", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latencyPulse", 32'(out_valid), 32'd1);
    checkOutput("basicSum", out_sum, 32'h04800000);
    checkOutput("basicSlice", 32'(out_sum[27:12]), 32'h4800);
    @(negedge clk);
    checkOutput("pulseOneCycle", 32'(out_valid), 32'd0);
    checkOutput("sumHeld", out_sum, 32'h04800000);
    waitIdle();

    // Saturation in both directions.
    setWeights(16'h7FFF);
    writeBias(16'h0000);
    setStim(16'h7FFF);
    applyStimulus(0);
    waitPulse("posSat", 32'h7FFFFFFF);
    waitIdle();
    setWeights(16'h8000);
    applyStimulus(0);
    waitPulse("negSat", 32'h80000000);
    waitIdle();

    // Back-to-back vectors, the second with one-cycle gaps.
    setWeights(16'h1000);
    writeBias(16'h0800);
    setStim(16'h1000);
    applyStimulus(0);
    setStim(16'hF000);
    applyStimulus(1);
    waitIdle();
    waitIdle();
    checkOutput("b2bDrained", 32'(expQ.size()), 32'd0);

    // Weight write while busy is dropped; the same write when idle takes effect.
    feedOne(16'h1000);
    feedOne(16'h1000);
    @(negedge clk);
    checkOutput("busyMid", 32'(busy), 32'd1);
    writeWeight(2'd1, 16'h2000);
    feedOne(16'h1000);
    feedOne(16'h1000);
    waitPulse("wrDropped", 32'h04800000);
    waitIdle();
    checkOutput("busyIdle", 32'(busy), 32'd0);
    writeWeight(2'd1, 16'h2000);
    setStim(16'h1000);
    applyStimulus(0);
    waitPulse("wrApplied", 32'h05800000);
    waitIdle();

    // Reset in the middle of a vector discards it.
    setWeights(16'h1000);
    feedOne(16'h1000);
    feedOne(16'h1000);
    rst_n = 1'b0;
    tbCnt = 0;
    modelBias = '0;
    lastFeedEdge = -100;
    @(negedge clk);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstOutSum", out_sum, 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycle();
    writeBias(16'h0800);
    setStim(16'h1000);
    applyStimulus(0);
    waitPulse("afterRst", 32'h04800000);
    waitIdle();

    // Randomized vectors, sometimes back-to-back with unchanged weights.
    for (int v = 0; v < 10; v++) begin
      if (v % 2 == 0) begin
        waitIdle();
        for (int a = 0; a < 4; a++) begin
          writeWeight(2'(a), ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000)
                                                        : 16'($urandom));
        end
        writeBias(16'($urandom));
      end
      for (int k = 0; k < 4; k++) begin
        stimVec[k] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      end
      applyStimulus(int'($urandom_range(0, 2)));
    end

    repeat (8) idleCycle();
    checkOutput("drainEmpty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
